// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the handshaked big-endian data memory.
// Lane bit 3 maps to the lowest byte address of a word (bits [31:24]).
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // The illegal size reports 4 bytes; it is rejected on its own anyway.
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: access_bytes = 3'd1;
            SZ_HALF: access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_en = 4'b1000 >> off;
            SZ_HALF: lane_en = 4'b1100 >> off;
            SZ_WORD: lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-lane storage: combinational 4-byte big-endian read window at an aligned
// word, synchronous per-lane writes. Contents are never reset.
module dmem_array #(
    parameter int DEPTH_BYTES = 256,
    localparam int NWORDS = DEPTH_BYTES / 4,
    localparam int WA = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic          clk,
    input  logic [WA-1:0] word_idx,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [NWORDS];

    assign rdata = mem[word_idx];

    always_ff @(posedge clk) begin
        if (we[3]) mem[word_idx][31:24] <= wdata[31:24];
        if (we[2]) mem[word_idx][23:16] <= wdata[23:16];
        if (we[1]) mem[word_idx][15:8]  <= wdata[15:8];
        if (we[0]) mem[word_idx][7:0]   <= wdata[7:0];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Request/response data memory controller: FSM, wait states, error checks,
// big-endian lane steering and load extension around dmem_array.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int NWORDS = DEPTH_BYTES / 4;
    localparam int WA     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t              state, state_nxt;
    logic [3:0]          wait_cnt;
    logic                we_q;
    logic                uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic                accept;
    logic [ADDR_W:0]     last_addr;
    logic                err_size, err_align, err_range, acc_err;
    logic [WA-1:0]       word_idx;
    logic [31:0]         rd_win;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         load_val;
    logic [31:0]         wr_dat;
    logic [3:0]          wr_we;

    assign accept = req_valid & req_ready;

    // Range check runs on the full address one bit wider, so nothing wraps or aliases.
    assign last_addr = {1'b0, addr_q} + (ADDR_W+1)'(access_bytes(size_q) - 3'd1);
    assign err_range = last_addr >= (ADDR_W+1)'(DEPTH_BYTES);
    assign err_size  = (size_q == 2'b11);
    assign err_align = ((size_q == SZ_HALF) && addr_q[0]) ||
                       ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    assign acc_err   = err_size | err_align | err_range;

    assign word_idx = WA'(addr_q >> 2);

    dmem_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .clk      (clk),
        .word_idx (word_idx),
        .we       (wr_we),
        .wdata    (wr_dat),
        .rdata    (rd_win)
    );

    // Offset 0 sits in the most significant lane of the window.
    assign rd_byte = rd_win[{~addr_q[1:0], 3'b000} +: 8];
    assign rd_half = rd_win[{~addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_win;
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_win;
        endcase
    end

    // Replicate narrow store data across lanes; the lane enables pick the target bytes.
    always_comb begin
        wr_dat = req_wdata_q_sel(size_q, wdata_q);
    end

    function automatic logic [31:0] req_wdata_q_sel(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SZ_BYTE: req_wdata_q_sel = {4{wd[7:0]}};
            SZ_HALF: req_wdata_q_sel = {2{wd[15:0]}};
            default: req_wdata_q_sel = wd;
        endcase
    endfunction

    assign wr_we = ((state == ACCESS) && we_q && !acc_err) ? lane_en(size_q, addr_q[1:0]) : 4'b0000;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
            end
            WAIT: begin
                if (wait_cnt >= 4'(WAIT_STATES)) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= req_we;
                uns_q    <= req_unsigned;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                wait_cnt <= 4'd1;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (state == ACCESS) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || we_q) ? 32'd0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Two instances (0 and 3 wait states) driven with directed and random
// transactions, checked against a byte-array reference model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        rsp_valid    [2];
    logic        rsp_ready    [2];
    logic [31:0] rsp_rdata    [2];
    logic        rsp_err      [2];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc [2];
    logic [7:0] mem_m [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ctrl #(.DEPTH_BYTES(256), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_ctrl #(.DEPTH_BYTES(256), .WAIT_STATES(3), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Reference: byte-addressed big-endian memory of 256 bytes, no wrap.
    task automatic model(input int d, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int n;
        longint unsigned last;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = {32'd0, a} + longint'(n) - 1;
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (last >= 256);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < n; k++) mem_m[d][a + k] = 8'(wd >> (8 * (n - 1 - k)));
            end else begin
                for (int k = 0; k < n; k++) rd = (rd << 8) | {24'd0, mem_m[d][a + k]};
                if (!uns && n < 4 && rd[8 * n - 1]) rd = rd | ~((32'd1 << (8 * n)) - 32'd1);
            end
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int lat;
        int exp_lat;
        logic [31:0] m_rd;
        logic m_er;
        exp_lat = (d == 0) ? 1 : 4;
        model(d, we, sz, uns, a, wd, m_rd, m_er);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
        req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
        lat = 0;
        while (!req_ready[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout d%0d: req_ready=%b required 1", d, req_ready[d]);
        end
        @(posedge clk);
        acc_cyc[d] = cyc;
        #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (!rsp_valid[d] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        vectors++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency d%0d addr=%h: got %0d required %0d", d, a, lat, exp_lat);
        end
        vectors++;
        if (rd !== m_rd) begin
            errors++;
            $display("FAIL rdata d%0d we=%b sz=%0d u=%b addr=%h: got %h required %h", d, we, sz, uns, a, rd, m_rd);
        end
        vectors++;
        if (er !== m_er) begin
            errors++;
            $display("FAIL err d%0d we=%b sz=%0d addr=%h: got %b required %b", d, we, sz, a, er, m_er);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state d%0d: rdy=%b vld=%b rd=%h err=%b required 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (req_ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset d%0d: got %b required 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_prefill;
        logic [31:0] rd;
        logic er;
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 256; a += 4) txn(d, 1'b1, 2'd2, 1'b0, 32'(a), $urandom, rd, er);
    endtask

    task automatic test_word_byte;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er);
        txn(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_word_0x10: got %h/%b required 11223344/0", rd, er);
        end
        txn(0, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'h00000011) begin
            errors++;
            $display("FAIL load_byte_0x10: got %h required 00000011", rd);
        end
        txn(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'h00000044) begin
            errors++;
            $display("FAIL load_byte_0x13: got %h required 00000044", rd);
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd, old;
        logic er;
        txn(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, old, er);
        txn(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'hABCDEFF0, rd, er);
        txn(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'hFFFFFFF0) begin
            errors++;
            $display("FAIL load_byte_signed: got %h required FFFFFFF0", rd);
        end
        txn(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'h000000F0) begin
            errors++;
            $display("FAIL load_byte_unsigned: got %h required 000000F0", rd);
        end
        txn(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        vectors++;
        if (rd !== ((old & 32'hFF00FFFF) | 32'h00F00000)) begin
            errors++;
            $display("FAIL byte_lane_only: got %h required %h", rd, (old & 32'hFF00FFFF) | 32'h00F00000);
        end
    endtask

    task automatic test_half_misalign;
        logic [31:0] rd, old;
        logic er;
        txn(0, 1'b1, 2'd1, 1'b0, 32'h32, 32'h12348001, rd, er);
        txn(0, 1'b0, 2'd1, 1'b0, 32'h32, 32'h0, rd, er);
        vectors++;
        if (rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL load_half_signed: got %h required FFFF8001", rd);
        end
        txn(0, 1'b0, 2'd1, 1'b0, 32'h31, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL half_misaligned: got %h/%b required 00000000/1", rd, er);
        end
        txn(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, old, er);
        txn(0, 1'b1, 2'd2, 1'b0, 32'h32, 32'hDEADBEEF, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL word_misaligned_store: err got %b required 1", er);
        end
        txn(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er);
        vectors++;
        if (rd !== old) begin
            errors++;
            $display("FAIL word_unchanged_0x30: got %h required %h", rd, old);
        end
        txn(0, 1'b0, 2'd3, 1'b0, 32'h30, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL illegal_size: got %h/%b required 00000000/1", rd, er);
        end
    endtask

    task automatic test_range;
        logic [31:0] rd, old;
        logic er;
        txn(0, 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL load_word_0xFC: err got %b required 0", er);
        end
        txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL load_word_0x100: got %h/%b required 00000000/1", rd, er);
        end
        txn(0, 1'b0, 2'd2, 1'b0, 32'hFE, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL load_word_0xFE: err got %b required 1", er);
        end
        txn(0, 1'b0, 2'd1, 1'b0, 32'hFFFFFFFE, 32'h0, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL load_half_top: err got %b required 1", er);
        end
        txn(0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, old, er);
        txn(0, 1'b1, 2'd0, 1'b0, 32'h1000_0000, {24'd0, ~old[7:0]}, rd, er);
        vectors++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL store_alias_err: err got %b required 1", er);
        end
        txn(0, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, rd, er);
        vectors++;
        if (rd !== old) begin
            errors++;
            $display("FAIL no_alias_byte0: got %h required %h", rd, old);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_rd, held;
        logic exp_er;
        int lat;
        model(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, exp_rd, exp_er);
        rsp_ready[1] = 1'b0;
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2;
        req_unsigned[1] = 1'b0; req_addr[1] = 32'h10; req_wdata[1] = 32'h0;
        lat = 0;
        while (!req_ready[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b1;
        lat = 0;
        while (!rsp_valid[1] && lat < 60) begin
            vectors++;
            if (req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL ready_low_busy: got %b required 0", req_ready[1]);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 4", lat);
        end
        held = rsp_rdata[1];
        vectors++;
        if (held !== exp_rd) begin
            errors++;
            $display("FAIL bp_rdata: got %h required %h", held, exp_rd);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            vectors++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp_rd || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: vld=%b rd=%h rdy=%b required 1 %h 0",
                         rsp_valid[1], rsp_rdata[1], req_ready[1], exp_rd);
            end
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rsp_valid got %b required 0", rsp_valid[1]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic er;
        int prev;
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
            prev = acc_cyc[d];
            for (int i = 0; i < 4; i++) begin
                txn(d, 1'b0, 2'd2, 1'b0, 32'(4 * $urandom_range(0, 63)), 32'h0, rd, er);
                vectors++;
                if (acc_cyc[d] - prev !== ((d == 0) ? 3 : 6)) begin
                    errors++;
                    $display("FAIL throughput d%0d: spacing %0d required %0d",
                             d, acc_cyc[d] - prev, (d == 0) ? 3 : 6);
                end
                prev = acc_cyc[d];
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] old, rd;
        logic er;
        int lat;
        model(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, old, er);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
        req_unsigned[1] = 1'b0; req_addr[1] = 32'h40; req_wdata[1] = ~old;
        lat = 0;
        while (!req_ready[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 || rsp_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: rdy=%b vld=%b rd=%h err=%b required 1 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 1", req_ready[1]);
        end
        txn(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er);
        vectors++;
        if (rd !== old) begin
            errors++;
            $display("FAIL dropped_store: got %h required %h", rd, old);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a;
        logic er;
        logic [1:0] sz;
        int r;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                r = $urandom_range(0, 15);
                sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
                r = $urandom_range(0, 9);
                a = (r < 7) ? 32'($urandom_range(0, 255)) : (r < 9) ? 32'($urandom_range(248, 263)) : $urandom;
                txn(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b1; acc_cyc[d] = 0;
        end
        test_reset;
        test_prefill;
        test_word_byte;
        test_byte_store;
        test_half_misalign;
        test_range;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
